mult_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one external 8x8 unsigned array multiplier (16-bit product) among NUM_REQ requesters.
- Accepts one operand pair at a time over a valid/ready handshake.
- Holds the operands stable on the multiplier inputs for MUL_LAT+1 cycles.
- Registers the product and returns it, tagged with the requester ID, over a valid/ready response channel.
- Sits between client blocks and the shared multiplier instance.

---
 rtl/mult_pkg.sv | 23 ++
 rtl/mult_rr_pick.sv | 33 +++
 rtl/mult_share_arbiter.sv | 129 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants, FSM state type and a width helper for the multiplier-sharing arbiter.
package mult_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bits needed to encode n distinct values; clog2(1) is 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_rr_pick.sv
// Round-robin pick: first valid requester after ptr, wrapping modulo NUM_REQ.
module mult_rr_pick
  import mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_valid
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    cand      = '0;
    // The previous winner is visited last, giving it the lowest priority.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!any_valid && req_valid[cand]) begin
        any_valid   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one external 8x8 multiplier among NUM_REQ clients: round-robin accept,
// hold operands while the multiplier settles, register and return the tagged product.
//
// state | meaning
// IDLE  | offering a grant to the next round-robin requester
// CALC  | operands held on mul_a/mul_b, counting down settle cycles
// RESP  | product registered, waiting for rsp_ready
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 0,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic [OP_W-1:0]         mul_a,
  output logic [OP_W-1:0]         mul_b,
  input  logic [PROD_W-1:0]       mul_p,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [PROD_W-1:0]       rsp_p,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy
);

  localparam int CNT_W = (MUL_LAT > 0) ? clog2(MUL_LAT + 1) : 1;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     ptr;
  logic [CNT_W-1:0]    cnt;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                any_valid;
  logic                cnt_done;
  logic [OP_W-1:0]     op_a, op_b;

  mult_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  assign cnt_done = (cnt == '0);

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        op_a = req_a[i*OP_W +: OP_W];
        op_b = req_b[i*OP_W +: OP_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = CALC;
      CALC:    if (cnt_done)  state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = 1'b0;
    case (state)
      IDLE:    req_ready = grant;
      CALC:    busy      = 1'b1;
      RESP:    busy      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= ID_W'(NUM_REQ - 1);
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_p     <= '0;
      rsp_id    <= '0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Grant is only raised on a valid bit, so any_valid is the handshake.
          if (any_valid) begin
            mul_a  <= op_a;
            mul_b  <= op_b;
            rsp_id <= grant_idx;
            ptr    <= grant_idx;
            cnt    <= CNT_W'(MUL_LAT);
          end
        end
        CALC: begin
          if (!cnt_done) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            rsp_p     <= mul_p;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter with a two-stage multiplier model (MUL_LAT=2).
module tb_mult_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int LAT     = 2;
  localparam int ID_W    = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_a;
  logic [NUM_REQ*8-1:0] req_b;
  logic [7:0]           mul_a, mul_b;
  logic [15:0]          mul_p;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [15:0]          rsp_p;
  logic [ID_W-1:0]      rsp_id;
  logic                 busy;

  mult_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .MUL_LAT (LAT),
    .ID_W    (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared multiplier that needs LAT extra cycles: sampling early returns a stale product.
  logic [15:0] p_d1, p_d2;
  always @(posedge clk) begin
    p_d1 <= {8'b0, mul_a} * {8'b0, mul_b};
    p_d2 <= p_d1;
  end
  assign mul_p = p_d2;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [15:0]     p;
  } exp_t;

  exp_t         q[$];
  int           n_pass, n_total;
  int           cyc, acc_cyc, mptr;
  logic         mbusy, prev_valid, prev_ready, no3, end_req, end_done;
  logic [17:0]  held;
  logic [7:0]   ea, eb;
  logic [NUM_REQ-1:0] hs_mask;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference rule: scan from the requester after the last winner, wrapping around.
  function automatic logic [NUM_REQ-1:0] rr_expect(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i;
      i = (last + k) % NUM_REQ;
      if (v[i]) return NUM_REQ'(1 << i);
    end
    return '0;
  endfunction

  initial begin
    n_pass = 0; n_total = 0; cyc = 0; acc_cyc = 0; mptr = NUM_REQ - 1;
    mbusy = 0; prev_valid = 0; prev_ready = 0; held = '0; ea = '0; eb = '0;
    hs_mask = '0; end_done = 0;
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("reset_ctrl", 32'({req_ready, mul_a, mul_b, rsp_valid, busy}), 32'd0);
      chk("reset_rsp", 32'({rsp_p, rsp_id}), 32'd0);
      q.delete();
      mptr = NUM_REQ - 1; mbusy = 0; prev_valid = 0; prev_ready = 0; hs_mask = '0;
    end else begin
      logic [NUM_REQ-1:0] er;
      chk("busy", 32'(busy), 32'(mbusy));
      if (!mbusy) begin
        er = rr_expect(req_valid, mptr);
        chk("req_ready", 32'(req_ready), 32'(er));
        for (int i = 0; i < NUM_REQ; i++) begin
          if (er[i]) begin
            exp_t e;
            ea = req_a[i*8 +: 8];
            eb = req_b[i*8 +: 8];
            e.id = ID_W'(i);
            e.p  = {8'b0, ea} * {8'b0, eb};
            q.push_back(e);
            mptr = i; mbusy = 1; acc_cyc = cyc;
          end
        end
      end else begin
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        chk("mul_hold", 32'({mul_a, mul_b}), 32'({ea, eb}));
      end
      hs_mask = req_valid & req_ready;
      if (prev_valid && !prev_ready)
        chk("rsp_hold", 32'({rsp_valid, rsp_p, rsp_id}), 32'({1'b1, held}));
      if (rsp_valid) begin
        chk("rsp_pending", 32'(q.size()), 32'd1);
        if (!prev_valid) chk("latency", 32'(cyc - acc_cyc), 32'(LAT + 2));
        if (rsp_ready && q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_p", 32'(rsp_p), 32'(e.p));
          if (no3) chk("withdrawn_id", 32'(rsp_id == ID_W'(3)), 32'd0);
          mbusy = 0;
        end
      end
      prev_valid = rsp_valid; prev_ready = rsp_ready; held = {rsp_p, rsp_id};
    end
    if (end_req && !end_done) begin
      chk("drain_empty", 32'(q.size()), 32'd0);
      end_done = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bound_fail(input string nm);
    $display("FAIL %s: bound expired at cycle %0d, %0d/%0d checks passed", nm, cyc, n_pass, n_total);
    $fatal(1, "bound expired");
  endtask

  task automatic wait_hs(input int i);
    for (int n = 0; n < 100; n++) begin
      step();
      if (hs_mask[i]) return;
    end
    bound_fail("hs_timeout");
  endtask

  task automatic wait_rsp();
    for (int n = 0; n < 100; n++) begin
      step();
      if (rsp_valid) return;
    end
    bound_fail("rsp_timeout");
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100; n++) begin
      step();
      if (!busy && !rsp_valid) return;
    end
    bound_fail("idle_timeout");
  endtask

  function automatic logic [7:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_valid[i]    = 1'b1;
  endtask

  initial begin
    int grants;
    rst_n = 0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 0;
    no3 = 0; end_req = 0;
    repeat (3) step();
    rst_n = 1;
    step();

    // All requesters valid from reset: order must start at 0 and rotate.
    rsp_ready = 1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, rnd_op(), rnd_op());
    grants = 0;
    for (int n = 0; n < 200 && grants < 8; n++) begin
      step();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs_mask[i]) begin
          set_req(i, rnd_op(), rnd_op());
          grants++;
        end
      end
    end
    if (grants < 8) bound_fail("rotate_timeout");
    req_valid = '0;
    wait_idle();

    // Single request from requester 1.
    set_req(1, 8'd12, 8'd11);
    wait_hs(1);
    req_valid[1] = 0;
    wait_idle();

    // Maximum operands.
    set_req(0, 8'd255, 8'd255);
    wait_hs(0);
    req_valid[0] = 0;
    wait_idle();

    // Backpressure with requester 2 waiting.
    rsp_ready = 0;
    set_req(1, 8'd7, 8'd9);
    wait_hs(1);
    req_valid[1] = 0;
    set_req(2, 8'd200, 8'd3);
    wait_rsp();
    repeat (5) step();
    rsp_ready = 1;
    wait_hs(2);
    req_valid[2] = 0;
    wait_idle();

    // Requester 3 raises valid for one cycle during RESP and withdraws.
    rsp_ready = 0;
    set_req(0, 8'd5, 8'd6);
    wait_hs(0);
    req_valid[0] = 0;
    wait_rsp();
    no3 = 1;
    set_req(3, 8'd1, 8'd1);
    step();
    req_valid[3] = 0;
    repeat (2) step();
    rsp_ready = 1;
    wait_idle();
    repeat (3) step();
    no3 = 0;

    // Reset while a transaction is in CALC.
    set_req(2, 8'd33, 8'd44);
    wait_hs(2);
    req_valid = '0;
    step();
    rst_n = 0;
    repeat (2) step();
    rst_n = 1;
    repeat (5) step();
    set_req(0, 8'd10, 8'd20);
    set_req(3, 8'd30, 8'd40);
    wait_hs(0);
    req_valid[0] = 0;
    wait_hs(3);
    req_valid[3] = 0;
    wait_idle();

    // Randomised traffic with withdrawals and random backpressure.
    for (int n = 0; n < 1500; n++) begin
      step();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs_mask[i]) begin
          if ($urandom_range(0, 9) < 7) set_req(i, rnd_op(), rnd_op());
          else req_valid[i] = 0;
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 19) == 0) req_valid[i] = 0;
        end else if ($urandom_range(0, 9) < 3) begin
          set_req(i, rnd_op(), rnd_op());
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end

    req_valid = '0;
    rsp_ready = 1;
    repeat (20) step();
    end_req = 1;
    repeat (2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
